// File: rtl/alu_issue_unit.sv
// Issue/capture front end for the execute-stage ALU: decodes RV32 opcode/funct fields into
// ALU control codes, one instruction in flight. Optional macro: ALU_ISSUE_BRANCH_TARGET_EN.
module alu_issue_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_operand1,
  output logic [XLEN-1:0] alu_operand2,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            is_branch,
  output logic            illegal,
  output logic [XLEN-1:0] branch_target
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_alu_control;
  logic [XLEN-1:0]   r_alu_operand1;
  logic [XLEN-1:0]   r_alu_operand2;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;
  logic              r_branch_taken;
  logic              r_is_branch;
  logic              r_illegal;

  logic [3:0]        w_ctrl;
  logic [XLEN-1:0]   w_op2;
  logic              w_is_branch;
  logic              w_illegal;
  logic              w_accept;

  // Opcode/funct translation; unsupported encodings fall back to ADD on rs1/rs2.
  always_comb begin
    w_ctrl      = 4'b0010;
    w_op2       = rs2_val;
    w_is_branch = 1'b0;
    w_illegal   = 1'b0;
    case (opcode)
      7'b0110011: begin
        case (funct3)
          3'b000:  w_ctrl = funct7_5 ? 4'b0110 : 4'b0010;
          3'b111:  w_ctrl = 4'b0000;
          3'b110:  w_ctrl = 4'b0001;
          default: w_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        case (funct3)
          3'b000:  begin w_ctrl = 4'b0010; w_op2 = imm; end
          3'b111:  begin w_ctrl = 4'b0000; w_op2 = imm; end
          3'b110:  begin w_ctrl = 4'b0001; w_op2 = imm; end
          default: w_illegal = 1'b1;
        endcase
      end
      7'b0000011, 7'b0100011: w_op2 = imm;
      7'b1100011: begin
        w_is_branch = 1'b1;
        case (funct3)
          3'b000:  w_ctrl = 4'b1000;
          3'b001:  w_ctrl = 4'b1001;
          3'b100:  w_ctrl = 4'b1010;
          3'b101:  w_ctrl = 4'b1011;
          3'b110:  w_ctrl = 4'b1100;
          3'b111:  w_ctrl = 4'b1101;
          default: begin w_is_branch = 1'b0; w_illegal = 1'b1; end
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // DONE accepts a new instruction on the same edge it retires the old one.
  assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  // Control FSM plus issue and capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_alu_control  <= 4'b0010;
      r_alu_operand1 <= {XLEN{1'b0}};
      r_alu_operand2 <= {XLEN{1'b0}};
      r_out_valid    <= 1'b0;
      r_result       <= {XLEN{1'b0}};
      r_branch_taken <= 1'b0;
      r_is_branch    <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_control  <= w_ctrl;
        r_alu_operand1 <= rs1_val;
        r_alu_operand2 <= w_op2;
        r_is_branch    <= w_is_branch;
        r_illegal      <= w_illegal;
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid) r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result       <= alu_result;
          r_branch_taken <= r_is_branch & alu_zero;
          r_out_valid    <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= in_valid ? S_EXEC : S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_BRANCH_TARGET_EN
  logic [XLEN-1:0] r_branch_target;

  // Target computed once at accept so it stays stable through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_target <= {XLEN{1'b0}};
    end else if (w_accept) begin
      r_branch_target <= pc + imm;
    end else begin
      r_branch_target <= r_branch_target;
    end
  end

  assign branch_target = r_branch_target;
`else
  // Masking keeps pc formally read while the target stays a constant zero.
  assign branch_target = pc & {XLEN{1'b0}};
`endif

  assign alu_control  = r_alu_control;
  assign alu_operand1 = r_alu_operand1;
  assign alu_operand2 = r_alu_operand2;
  assign out_valid    = r_out_valid;
  assign result       = r_result;
  assign branch_taken = r_branch_taken;
  assign is_branch    = r_is_branch;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a behavioural ALU on the issue outputs.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, funct7_5, alu_zero, out_valid, out_ready;
  logic        branch_taken, is_branch, illegal;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  alu_control;
  logic [31:0] rs1_val, rs2_val, imm, pc, alu_operand1, alu_operand2, alu_result, result;
  logic [31:0] branch_target;

`ifdef ALU_ISSUE_BRANCH_TARGET_EN
  localparam bit TGT_EN = 1'b1;
`else
  localparam bit TGT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic        bt;
    logic        br;
    logic        ill;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_issue_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .alu_control(alu_control), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .is_branch(is_branch), .illegal(illegal),
    .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: zero flag carries the branch condition for branch codes.
  always_comb begin
    case (alu_control)
      4'b0110: alu_result = alu_operand1 - alu_operand2;
      4'b0000: alu_result = alu_operand1 & alu_operand2;
      4'b0001: alu_result = alu_operand1 | alu_operand2;
      4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101:
               alu_result = alu_operand1 - alu_operand2;
      default: alu_result = alu_operand1 + alu_operand2;
    endcase
    case (alu_control)
      4'b1000: alu_zero = (alu_operand1 == alu_operand2);
      4'b1001: alu_zero = (alu_operand1 != alu_operand2);
      4'b1010: alu_zero = ($signed(alu_operand1) <  $signed(alu_operand2));
      4'b1011: alu_zero = ($signed(alu_operand1) >= $signed(alu_operand2));
      4'b1100: alu_zero = (alu_operand1 <  alu_operand2);
      4'b1101: alu_zero = (alu_operand1 >= alu_operand2);
      default: alu_zero = (alu_result == 32'd0);
    endcase
  end

  function automatic exp_t observed();
    return {alu_control, alu_operand1, alu_operand2, result, branch_taken, is_branch,
            illegal, branch_target};
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] p, input logic [31:0] i);
    return TGT_EN ? (p + i) : 32'd0;
  endfunction

  // Drives one instruction, records its expectation, returns after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic [31:0] p, input exp_t e);
    int k;
    opcode = op; funct3 = f3; funct7_5 = f7;
    rs1_val = a; rs2_val = b; imm = im; pc = p;
    in_valid = 1'b1;
    exp_q.push_back(e);
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    e = {4'b0010, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0};
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_cmp++;
    if (observed() !== e) begin
      n_err++; $display("FAIL reset_regs: got %h want %h", observed(), e);
    end
  endtask

  task automatic test_sub();
    int cyc;
    exp_t e, o;
    send(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd99, 32'h200,
         {4'b0110, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0, tgt_of(32'h200, 32'd99)});
    n_cmp++;
    if (out_valid !== 1'b0 || alu_control !== 4'b0110) begin
      n_err++; $display("FAIL sub_exec: out_valid=%b ctrl=%b want 0/0110", out_valid, alu_control);
    end
    wait_out(cyc);
    n_cmp++;
    if (cyc !== 1) begin
      n_err++; $display("FAIL sub_latency: got %0d cycles want 1", cyc);
    end
    e = exp_q.pop_front(); o = observed();
    n_cmp++;
    if (o !== e) begin
      n_err++; $display("FAIL sub_result: got %h want %h", o, e);
    end
    release_out();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL sub_retire: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_addi();
    int cyc;
    exp_t e, o;
    send(7'b0010011, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'd55, 32'd1, 32'h300,
         {4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, tgt_of(32'h300, 32'd1)});
    wait_out(cyc);
    e = exp_q.pop_front(); o = observed();
    n_cmp++;
    if (cyc !== 1 || o !== e) begin
      n_err++; $display("FAIL addi: cyc=%0d got %h want %h", cyc, o, e);
    end
    release_out();
  endtask

  task automatic test_bne();
    int cyc;
    exp_t e, o;
    send(7'b1100011, 3'b001, 1'b0, 32'd5, 32'd6, 32'hFFFF_FFF0, 32'h100,
         {4'b1001, 32'd5, 32'd6, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0,
          (TGT_EN ? 32'h0000_00F0 : 32'd0)});
    wait_out(cyc);
    e = exp_q.pop_front(); o = observed();
    n_cmp++;
    if (cyc !== 1 || o !== e) begin
      n_err++; $display("FAIL bne: cyc=%0d got %h want %h", cyc, o, e);
    end
    release_out();
  endtask

  task automatic test_illegal();
    int cyc;
    exp_t e, o;
    send(7'b1110011, 3'b000, 1'b0, 32'd4, 32'd9, 32'd16, 32'h40,
         {4'b0010, 32'd4, 32'd9, 32'd13, 1'b0, 1'b0, 1'b1, tgt_of(32'h40, 32'd16)});
    wait_out(cyc);
    e = exp_q.pop_front(); o = observed();
    n_cmp++;
    if (cyc !== 1 || o !== e) begin
      n_err++; $display("FAIL illegal_op: cyc=%0d got %h want %h", cyc, o, e);
    end
    release_out();
  endtask

  // Table of other encodings: op, f3, f7, rs1, rs2, imm, expected ctrl/op2/res/bt/br/ill.
  task automatic test_mix();
    logic [6:0]  t_op  [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h63,
                                7'h63, 7'h63, 7'h63, 7'h63, 7'h13, 7'h33};
    logic [2:0]  t_f3  [12] = '{3'd7, 3'd6, 3'd2, 3'd2, 3'd0, 3'd4,
                                3'd5, 3'd6, 3'd7, 3'd2, 3'd1, 3'd4};
    logic [31:0] t_a   [12] = '{32'hF0F0_1234, 32'h0000_0F00, 32'h1000, 32'h2000, 32'd5,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd3, 32'd3, 32'd20};
    logic [31:0] t_b   [12] = '{32'h0FF0_FFFF, 32'd7, 32'd8, 32'd8, 32'd6, 32'd1, 32'd1,
                                32'd1, 32'd1, 32'd4, 32'd4, 32'd2};
    logic [31:0] t_imm [12] = '{32'd11, 32'h0000_00F0, 32'd4, 32'hFFFF_FFFC, 32'd12, 32'd8,
                                32'd8, 32'd8, 32'd8, 32'd8, 32'd100, 32'd5};
    logic [3:0]  t_c   [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1010,
                                4'b1011, 4'b1100, 4'b1101, 4'b0010, 4'b0010, 4'b0010};
    logic [31:0] t_op2 [12] = '{32'h0FF0_FFFF, 32'h0000_00F0, 32'd4, 32'hFFFF_FFFC, 32'd6,
                                32'd1, 32'd1, 32'd1, 32'd1, 32'd4, 32'd4, 32'd2};
    logic [31:0] t_res [12] = '{32'h00F0_1234, 32'h0000_0FF0, 32'h1004, 32'h1FFC,
                                32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                32'hFFFF_FFFE, 32'd7, 32'd7, 32'd22};
    logic [2:0]  t_fl  [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b010,
                                3'b010, 3'b110, 3'b001, 3'b001, 3'b001};
    int cyc;
    exp_t e, o;
    logic [31:0] p;
    for (int i = 0; i < 12; i++) begin
      p = 32'h400 + 32'(i * 4);
      send(t_op[i], t_f3[i], 1'b1, t_a[i], t_b[i], t_imm[i], p,
           {t_c[i], t_a[i], t_op2[i], t_res[i], t_fl[i], tgt_of(p, t_imm[i])});
      wait_out(cyc);
      e = exp_q.pop_front(); o = observed();
      n_cmp++;
      if (cyc !== 1 || o !== e) begin
        n_err++; $display("FAIL mix_%0d: cyc=%0d got %h want %h", i, cyc, o, e);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    exp_t e, o;
    send(7'b0110011, 3'b000, 1'b1, 32'd20, 32'd5, 32'd0, 32'h500,
         {4'b0110, 32'd20, 32'd5, 32'd15, 1'b0, 1'b0, 1'b0, tgt_of(32'h500, 32'd0)});
    wait_out(cyc);
    e = exp_q.pop_front();
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
    rs1_val = 32'd1; rs2_val = 32'd2; imm = 32'd64; pc = 32'h600;
    in_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      o = observed();
      n_cmp++;
      if (cyc !== 1 || o !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL b2b_stall_%0d: cyc=%0d ov=%b ir=%b got %h want %h",
                          s, cyc, out_valid, in_ready, o, e);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready: in_ready=%b want 1", in_ready);
    end
    exp_q.push_back({4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, tgt_of(32'h600, 32'd64)});
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || alu_control !== 4'b0010 || alu_operand1 !== 32'd1) begin
      n_err++; $display("FAIL b2b_accept: ov=%b ctrl=%b op1=%h want 0/0010/1",
                        out_valid, alu_control, alu_operand1);
    end
    wait_out(cyc);
    e = exp_q.pop_front(); o = observed();
    n_cmp++;
    if (cyc !== 1 || o !== e) begin
      n_err++; $display("FAIL b2b_second: cyc=%0d got %h want %h", cyc, o, e);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    exp_t z;
    z = {4'b0010, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0};
    // Still in DONE from the previous test with out_ready low.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== z) begin
      n_err++; $display("FAIL reset_done: ov=%b ir=%b got %h want %h",
                        out_valid, in_ready, observed(), z);
    end
    send(7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'd4, 32'h700,
         {4'b1000, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 1'b0, tgt_of(32'h700, 32'd4)});
    void'(exp_q.pop_front());
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_out(cyc);
    n_cmp++;
    if (cyc !== 20 || in_ready !== 1'b1 || observed() !== z) begin
      n_err++; $display("FAIL reset_exec: idle_cycles=%0d ir=%b got %h want 20 cycles idle, %h",
                        cyc, in_ready, observed(), z);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    rs1_val = 32'd0; rs2_val = 32'd0; imm = 32'd0; pc = 32'd0;
    test_reset();
    test_sub();
    test_addi();
    test_bne();
    test_illegal();
    test_mix();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front end that drives the execute-stage ALU. Accepts one decoded RV32 instruction per handshake, translates opcode/funct3/funct7 into the 4-bit ALU control code, presents registered operands to the combinational ALU, then captures the ALU result and zero flag and returns them downstream as a result plus a branch decision. It sits between decode and writeback/PC-select, one instruction in flight at a time.

## Interface
- XLEN, 32, datapath width for operands, immediate, pc and result.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  unit can accept
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7_5  in  1  instruction[30]
- rs1_val  in  XLEN  source 1 value
- rs2_val  in  XLEN  source 2 value
- imm  in  XLEN  sign-extended immediate
- pc  in  XLEN  instruction address
- alu_control  out  4  registered code to ALU
- alu_operand1  out  XLEN  registered operand 1
- alu_operand2  out  XLEN  registered operand 2
- alu_result  in  XLEN  ALU result (combinational return)
- alu_zero  in  1  ALU zero flag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  XLEN  captured ALU result
- branch_taken  out  1  branch condition true
- is_branch  out  1  instruction was a branch
- illegal  out  1  unsupported encoding
- branch_target  out  XLEN  pc + imm (see Configuration)

## Operation
- Codes: ADD 0010, SUB 0110, AND 0000, OR 0001, BEQ 1000, BNE 1001, BLT 1010, BGE 1011, BLTU 1100, BGEU 1101.
- Decode: R-type 0110011: f3 000 → ADD (funct7_5=0) / SUB (=1); 111 AND; 110 OR; operand2=rs2_val. I-type 0010011: f3 000 ADD, 111 AND, 110 OR; funct7_5 ignored; operand2=imm. Load 0000011 / store 0100011: ADD, operand2=imm. Branch 1100011: f3 000/001/100/101/110/111 → BEQ/BNE/BLT/BGE/BLTU/BGEU, operand2=rs2_val, is_branch=1. operand1=rs1_val always.
- Anything else (incl. branch f3 010/011, other R/I f3): code ADD, operands rs1_val/rs2_val, illegal=1, is_branch=0.
- FSM: IDLE → EXEC → DONE.
  - IDLE: in_ready=1; in_valid → latch decode into alu_* regs and flags, go EXEC.
  - EXEC: ALU inputs stable; at end of cycle capture result=alu_result, branch_taken=is_branch & alu_zero; go DONE.
  - DONE: out_valid=1, outputs held stable until out_ready. out_ready & !in_valid → IDLE. out_ready & in_valid → accept new instruction same edge, go EXEC (in_ready=out_ready in DONE).
- Non-branch: branch_taken=0 regardless of alu_zero.
- alu_* outputs hold last issued values outside EXEC.

## Timing
- Accept at edge N (in_valid & in_ready) → EXEC during cycle N+1 → out_valid from cycle N+2.
- Max throughput one instruction per 2 cycles (DONE→EXEC bypass).
- Reset (any state, incl. mid-EXEC or DONE with out_ready low): state IDLE, in_ready=1 in following cycle, out_valid=0, alu_control=0010, alu_operand1/2=0, result=0, branch_taken=0, is_branch=0, illegal=0, branch_target=0. In-flight instruction discarded.
- in_valid ignored in EXEC and in DONE when out_ready=0.
- out_valid never deasserts without out_ready except by reset.

## Configuration
- ALU_ISSUE_BRANCH_TARGET_EN defined: branch_target latched on accept as (pc + imm) mod 2^XLEN for every instruction; held through DONE.
- Not defined: no adder; branch_target constant 0; pc ignored.

## Test plan
- Reset mid-DONE (out_ready=0) → next cycle out_valid=0, in_ready=1, alu_control=0010, all outputs 0.
- R-type SUB, rs1=10, rs2=3, model ALU returns 7 → alu_control=0110, out_valid at N+2, result=7, branch_taken=0, illegal=0.
- ADDI rs1=0xFFFFFFFF, imm=1, ALU returns 0 → operand2=1, result=0, branch_taken=0 (not branch despite zero=1).
- BNE f3=001, ALU zero=1 → alu_control=1001, is_branch=1, branch_taken=1; with macro, pc=0x100, imm=0xFFFFFFF0 → branch_target=0xF0; without macro → 0.
- Opcode 1110011 → illegal=1, alu_control=0010, is_branch=0.
- Back-to-back: out_ready held 0 three cycles then 1 with in_valid=1 → result stable during stall, second instruction accepted same edge, its out_valid two cycles later.
